// File: rtl/hex_frame_host.sv
// rtl/hex_frame_host.sv - sends a 128-bit block as 32 hex characters and decodes a 32-character hex response
// Optional feature macro: HEX_FRAME_HOST_UPPERCASE_EN (accept 'A'-'F' in responses)
module hex_frame_host #(
    parameter int GAP_CYCLES     = 3000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] tx_block,
    output logic [7:0]   tx_byte,
    output logic         transmit,
    input  logic         tx_busy,
    input  logic [7:0]   rx_byte,
    input  logic         received,
    output logic [127:0] rx_block,
    output logic         done,
    output logic         busy,
    output logic         char_error,
    output logic         timeout
);

    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SEND, S_WAIT_TX, S_GAP, S_RECV, S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [127:0]   block_q, block_d;
    logic [127:0]   shadow_q, shadow_d;
    logic [127:0]   rx_block_q, rx_block_d;
    logic [4:0]     tx_cnt_q, tx_cnt_d;
    logic [4:0]     rx_cnt_q, rx_cnt_d;
    logic [GW-1:0]  gap_cnt_q, gap_cnt_d;
    logic [TW-1:0]  to_cnt_q, to_cnt_d;
    logic           first_q, first_d;
    logic [7:0]     tx_byte_q, tx_byte_d;
    logic           char_error_q, char_error_d;
    logic           done_q, done_d;
    logic           timeout_q, timeout_d;

    logic [6:0]     tx_msb;
    logic [6:0]     rx_msb;
    logic [4:0]     dec;

    // Returns {invalid, nibble}; invalid characters decode to nibble 0.
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        logic [4:0] r;
        r = 5'b1_0000;
        if (c >= 8'h30 && c <= 8'h39) begin
            r = {1'b0, c[3:0]};
        end else if (c >= 8'h61 && c <= 8'h66) begin
            r = {1'b0, c[3:0] + 4'd9};
        end
`ifdef HEX_FRAME_HOST_UPPERCASE_EN
        else if (c >= 8'h41 && c <= 8'h46) begin
            r = {1'b0, c[3:0] + 4'd9};
        end
`endif
        return r;
    endfunction

    function automatic logic [7:0] hex_encode(input logic [3:0] n);
        return (n < 4'd10) ? {4'h3, n} : (8'h57 + {4'h0, n});
    endfunction

    assign tx_msb = 7'd127 - {tx_cnt_q, 2'b00};
    assign rx_msb = 7'd127 - {rx_cnt_q, 2'b00};
    assign dec    = hex_decode(rx_byte);

    always_comb begin
        state_d      = state_q;
        block_d      = block_q;
        shadow_d     = shadow_q;
        rx_block_d   = rx_block_q;
        tx_cnt_d     = tx_cnt_q;
        rx_cnt_d     = rx_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        to_cnt_d     = to_cnt_q;
        first_d      = first_q;
        tx_byte_d    = tx_byte_q;
        char_error_d = char_error_q;
        done_d       = 1'b0;
        timeout_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    block_d      = tx_block;
                    shadow_d     = '0;
                    tx_cnt_d     = '0;
                    rx_cnt_d     = '0;
                    char_error_d = 1'b0;
                    state_d      = S_LOAD;
                end
            end
            S_LOAD: begin
                tx_byte_d = hex_encode(block_q[tx_msb -: 4]);
                state_d   = S_SEND;
            end
            S_SEND: begin
                first_d = 1'b1;
                state_d = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                // The UART may not raise tx_busy until a cycle after the strobe.
                if (first_q) begin
                    first_d = 1'b0;
                end else if (!tx_busy) begin
                    if (tx_cnt_q != 5'd31) begin
                        gap_cnt_d = '0;
                        state_d   = S_GAP;
                    end else begin
                        to_cnt_d = '0;
                        state_d  = S_RECV;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    tx_cnt_d = tx_cnt_q + 5'd1;
                    state_d  = S_LOAD;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            S_RECV: begin
                if (received) begin
                    shadow_d[rx_msb -: 4] = dec[3:0];
                    if (dec[4]) char_error_d = 1'b1;
                    to_cnt_d = '0;
                    rx_cnt_d = rx_cnt_q + 5'd1;
                    if (rx_cnt_q == 5'd31) state_d = S_DONE;
                end else if (to_cnt_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            S_DONE: begin
                rx_block_d = shadow_q;
                done_d     = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            block_q      <= '0;
            shadow_q     <= '0;
            rx_block_q   <= '0;
            tx_cnt_q     <= '0;
            rx_cnt_q     <= '0;
            gap_cnt_q    <= '0;
            to_cnt_q     <= '0;
            first_q      <= 1'b0;
            tx_byte_q    <= 8'h00;
            char_error_q <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            block_q      <= block_d;
            shadow_q     <= shadow_d;
            rx_block_q   <= rx_block_d;
            tx_cnt_q     <= tx_cnt_d;
            rx_cnt_q     <= rx_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            to_cnt_q     <= to_cnt_d;
            first_q      <= first_d;
            tx_byte_q    <= tx_byte_d;
            char_error_q <= char_error_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
        end
    end

    assign tx_byte    = tx_byte_q;
    assign transmit   = (state_q == S_SEND);
    assign busy       = (state_q != S_IDLE);
    assign rx_block   = rx_block_q;
    assign done       = done_q;
    assign char_error = char_error_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_hex_frame_host.sv
// tb/tb_hex_frame_host.sv - directed and randomized self-checking bench for hex_frame_host
module tb_hex_frame_host;

    localparam int GAP = 5;
    localparam int TMO = 100;

    logic         clk = 1'b0;
    logic         rst, start, tx_busy, received;
    logic [127:0] tx_block, rx_block;
    logic [7:0]   tx_byte, rx_byte;
    logic         transmit, done, busy, char_error, timeout;

    int errors = 0, checks = 0;
    int cyc = 0, done_cnt = 0, tmo_cnt = 0, tmo_cyc = 0;
    int gap_viol = 0, last_fall = 0, busy_left = 0, last_strobe = 0;
    logic [7:0]   txq[$];
    logic [7:0]   resp[32];
    logic [127:0] exp_rx = '0;

    hex_frame_host #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .tx_block(tx_block),
        .tx_byte(tx_byte), .transmit(transmit), .tx_busy(tx_busy),
        .rx_byte(rx_byte), .received(received), .rx_block(rx_block),
        .done(done), .busy(busy), .char_error(char_error), .timeout(timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // UART transmitter model: records characters, stays busy a random time.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) begin
                    tx_busy   = 1'b0;
                    last_fall = cyc;
                end
            end
            if (transmit === 1'b1) begin
                txq.push_back(tx_byte);
                if (txq.size() > 1 && cyc - last_fall < GAP) gap_viol++;
                tx_busy   = 1'b1;
                busy_left = $urandom_range(1, 6);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
            if (timeout === 1'b1) begin
                tmo_cnt++;
                tmo_cyc = cyc;
            end
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference decode: {invalid, nibble} straight from the character rules.
    function automatic logic [4:0] ref_decode(input logic [7:0] c);
        if (c >= "0" && c <= "9") return {1'b0, 4'(c - 8'h30)};
        if (c >= "a" && c <= "f") return {1'b0, 4'(c - 8'h61 + 8'd10)};
`ifdef HEX_FRAME_HOST_UPPERCASE_EN
        if (c >= "A" && c <= "F") return {1'b0, 4'(c - 8'h41 + 8'd10)};
`endif
        return 5'b1_0000;
    endfunction

    task automatic load_resp(input string s);
        for (int i = 0; i < 32; i++) resp[i] = s[i];
    endtask

    task automatic send_frame(input logic [127:0] blk, input bit stray, input bit extra);
        string exp_s;
        logic [255:0] obs, exp;
        int n;
        txq.delete();
        @(negedge clk);
        start = 1'b1;
        tx_block = blk;
        @(negedge clk);
        start = 1'b0;
        tx_block = {$urandom, $urandom, $urandom, $urandom};
        chk("busy_after_start", 256'(busy), 256'(1'b1));
        if (stray) begin
            rx_byte = "Z";
            received = 1'b1;
            @(negedge clk);
            received = 1'b0;
        end
        n = 0;
        while (txq.size() < 32 && n < 5000) begin
            start = extra && (n % 40 == 10);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        n = 0;
        while (tx_busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        exp_s = $sformatf("%032h", blk);
        obs = '0;
        exp = '0;
        for (int i = 0; i < 32; i++) begin
            exp[255 - 8*i -: 8] = exp_s[i];
            if (i < txq.size()) obs[255 - 8*i -: 8] = txq[i];
        end
        chk("tx_chars", obs, exp);
        chk("tx_gap_violations", 256'(gap_viol), 256'(0));
    endtask

    task automatic respond(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            @(negedge clk);
            rx_byte = resp[i];
            received = 1'b1;
            last_strobe = cyc;
            @(negedge clk);
            received = 1'b0;
            rx_byte = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    task automatic do_frame(input logic [127:0] blk, input bit stray, input bit extra);
        int d0, n;
        logic       err;
        logic [4:0] d;
        send_frame(blk, stray, extra);
        d0 = done_cnt;
        respond(32);
        n = 0;
        while (done_cnt == d0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        err = 1'b0;
        for (int i = 0; i < 32; i++) begin
            d = ref_decode(resp[i]);
            exp_rx = {exp_rx[123:0], d[3:0]};
            err |= d[4];
        end
        chk("done_pulses", 256'(done_cnt - d0), 256'(1));
        chk("rx_block", 256'(rx_block), 256'(exp_rx));
        chk("char_error", 256'(char_error), 256'(err));
        chk("busy_after_done", 256'(busy), 256'(1'b0));
        chk("tx_count", 256'(txq.size()), 256'(32));
    endtask

    initial begin
        string pool;
        int t0, d0, n;
        rst = 1'b1; start = 1'b0; received = 1'b0; rx_byte = 8'h00; tx_block = '0;
        pool = "0123456789abcdefABCDEFgz:";
        repeat (3) @(negedge clk);
        chk("rst_transmit", 256'(transmit), 256'(0));
        chk("rst_done", 256'(done), 256'(0));
        chk("rst_timeout", 256'(timeout), 256'(0));
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_char_error", 256'(char_error), 256'(0));
        chk("rst_tx_byte", 256'(tx_byte), 256'(0));
        chk("rst_rx_block", 256'(rx_block), 256'(0));
        rst = 1'b0;

        load_resp("00112233445566778899aabbccddeeff");
        do_frame(128'h0123456789abcdeffedcba9876543210, 1'b1, 1'b0);

        for (int i = 0; i < 32; i++) resp[i] = pool[$urandom_range(0, 15)];
        resp[5] = "G";
        do_frame({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);

        load_resp({"ABCDEF", "ABCDEF", "ABCDEF", "ABCDEF", "ABCDEF", "AB"});
        do_frame({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);

        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 32; i++) resp[i] = pool[$urandom_range(0, pool.len() - 1)];
            do_frame({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
        end

        // Timeout: ten characters then silence.
        for (int i = 0; i < 32; i++) resp[i] = pool[$urandom_range(0, 15)];
        resp[3] = "x";
        send_frame({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
        t0 = tmo_cnt;
        d0 = done_cnt;
        respond(10);
        n = 0;
        while (tmo_cnt == t0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("timeout_pulses", 256'(tmo_cnt - t0), 256'(1));
        chk("timeout_latency", 256'(tmo_cyc - last_strobe - 1), 256'(TMO));
        chk("timeout_rx_kept", 256'(rx_block), 256'(exp_rx));
        chk("timeout_busy", 256'(busy), 256'(0));
        chk("timeout_no_done", 256'(done_cnt - d0), 256'(0));
        chk("timeout_char_error", 256'(char_error), 256'(1));

        // Reset during the gap after the 7th character.
        txq.delete();
        @(negedge clk);
        start = 1'b1;
        tx_block = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (txq.size() < 7 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (tx_busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("gap_chars_before_rst", 256'(txq.size()), 256'(7));
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 256'(busy), 256'(0));
        chk("midrst_tx_byte", 256'(tx_byte), 256'(0));
        chk("midrst_rx_block", 256'(rx_block), 256'(0));
        chk("midrst_char_error", 256'(char_error), 256'(0));
        rst = 1'b0;
        exp_rx = '0;
        for (int i = 0; i < 32; i++) resp[i] = pool[$urandom_range(0, 21)];
        do_frame({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b1);
        repeat (40) @(negedge clk);
        chk("no_extra_frame", 256'(txq.size()), 256'(32));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
